// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU-control decode stage.
// Holds the 5-bit ALU control codes, the alu_op selector values and the
// funct7 patterns that distinguish base, alternate (SUB/SRA) and RV32M ops.
package alu_ctrl_pkg;

    localparam int CODE_W = 5;

    // ALU control codes
    localparam logic [CODE_W-1:0] ALU_AND    = 5'd0;
    localparam logic [CODE_W-1:0] ALU_OR     = 5'd1;
    localparam logic [CODE_W-1:0] ALU_XOR    = 5'd2;
    localparam logic [CODE_W-1:0] ALU_ADD    = 5'd3;
    localparam logic [CODE_W-1:0] ALU_SUB    = 5'd4;
    localparam logic [CODE_W-1:0] ALU_SLL    = 5'd5;
    localparam logic [CODE_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [CODE_W-1:0] ALU_SLT    = 5'd7;
    localparam logic [CODE_W-1:0] ALU_SLTU   = 5'd8;
    localparam logic [CODE_W-1:0] ALU_SRA    = 5'd9;
    localparam logic [CODE_W-1:0] ALU_BEQ    = 5'd10;
    localparam logic [CODE_W-1:0] ALU_BNE    = 5'd11;
    localparam logic [CODE_W-1:0] ALU_BLT    = 5'd12;
    localparam logic [CODE_W-1:0] ALU_BLTU   = 5'd13;
    localparam logic [CODE_W-1:0] ALU_BGE    = 5'd14;
    localparam logic [CODE_W-1:0] ALU_BGEU   = 5'd15;
    localparam logic [CODE_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [CODE_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [CODE_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [CODE_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [CODE_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [CODE_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [CODE_W-1:0] ALU_REM    = 5'd22;
    localparam logic [CODE_W-1:0] ALU_REMU   = 5'd23;

    // alu_op selector values
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_OP_SUB    = 2'b10;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b11;

    // funct7 patterns
    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALU-control decoder.
// Ports: alu_op/funct_3/funct_7/op_is_reg in; alu_ctrl (CTRL_W, zero-extended
// 5-bit code) and illegal out. Illegal encodings always report ADD.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W   = 5,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct_3,
    input  logic [6:0]        funct_7,
    input  logic              op_is_reg,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal
);

    logic [CODE_W-1:0] code_s;
    logic              illegal_s;

    // Decode table: select a code, then flag encodings outside the ISA
    always_comb begin
        code_s    = ALU_ADD;
        illegal_s = 1'b0;
        case (alu_op)
            ALU_OP_ADD: code_s = ALU_ADD;
            ALU_OP_SUB: code_s = ALU_SUB;
            ALU_OP_FUNCT: begin
                if (op_is_reg && (funct_7 == FUNCT7_MULDIV)) begin
                    // RV32M ops are laid out contiguously in funct3 order
                    if (ENABLE_M) begin
                        code_s = ALU_MUL + {2'b00, funct_3};
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    case (funct_3)
                        3'b000: begin
                            if (op_is_reg && (funct_7 == FUNCT7_ALT)) begin
                                code_s = ALU_SUB;
                            end else begin
                                code_s = ALU_ADD;
                            end
                        end
                        3'b001: code_s = ALU_SLL;
                        3'b010: code_s = ALU_SLT;
                        3'b011: code_s = ALU_SLTU;
                        3'b100: code_s = ALU_XOR;
                        3'b101: begin
                            if (funct_7 == FUNCT7_ALT) begin
                                code_s = ALU_SRA;
                            end else begin
                                code_s = ALU_SRL;
                            end
                        end
                        3'b110: code_s = ALU_OR;
                        3'b111: code_s = ALU_AND;
                        default: code_s = ALU_ADD;
                    endcase
                    if (op_is_reg) begin
                        // R-type: only base, or alternate on ADD/SRL slots
                        if ((funct_7 == FUNCT7_BASE) ||
                            ((funct_7 == FUNCT7_ALT) &&
                             ((funct_3 == 3'b000) || (funct_3 == 3'b101)))) begin
                            illegal_s = 1'b0;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end else begin
                        // I-type: funct7 is immediate except for shifts
                        if ((funct_3 == 3'b001) && (funct_7 != FUNCT7_BASE)) begin
                            illegal_s = 1'b1;
                        end else if ((funct_3 == 3'b101) && (funct_7 != FUNCT7_BASE) &&
                                     (funct_7 != FUNCT7_ALT)) begin
                            illegal_s = 1'b1;
                        end else begin
                            illegal_s = 1'b0;
                        end
                    end
                end
            end
            ALU_OP_BRANCH: begin
                case (funct_3)
                    3'b000: code_s = ALU_BEQ;
                    3'b001: code_s = ALU_BNE;
                    3'b100: code_s = ALU_BLT;
                    3'b101: code_s = ALU_BGE;
                    3'b110: code_s = ALU_BLTU;
                    3'b111: code_s = ALU_BGEU;
                    default: illegal_s = 1'b1;
                endcase
            end
            default: code_s = ALU_ADD;
        endcase
        if (illegal_s) begin
            code_s = ALU_ADD;
        end else begin
            code_s = code_s;
        end
    end

    assign alu_ctrl = CTRL_W'(code_s);
    assign illegal  = illegal_s;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered, flow-controlled ALU-control decode stage.
// Ports: i_clk, i_rst_n (async, active low), i_flush (sync);
// upstream i_valid/o_ready with i_alu_op, i_funct_3, i_funct_7, i_op_is_reg,
// i_tag; downstream o_valid/i_ready with o_alu_ctrl, o_illegal, o_tag;
// o_count is FIFO occupancy. Requests are decoded on push and buffered in a
// DEPTH-entry FIFO. All outputs come straight from flops.
module alu_decode_stage
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W   = 5,
    parameter int TAG_W    = 32,
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [1:0]                 i_alu_op,
    input  logic [2:0]                 i_funct_3,
    input  logic [6:0]                 i_funct_7,
    input  logic                       i_op_is_reg,
    input  logic [TAG_W-1:0]           i_tag,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [CTRL_W-1:0]          o_alu_ctrl,
    output logic                       o_illegal,
    output logic [TAG_W-1:0]           o_tag,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CTRL_W-1:0] ctrl_mem_r [DEPTH];
    logic              ill_mem_r  [DEPTH];
    logic [TAG_W-1:0]  tag_mem_r  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic              valid_r, ready_r;
    logic [CTRL_W-1:0] head_ctrl_r, head_ctrl_s, dec_ctrl_s;
    logic              head_ill_r, head_ill_s, dec_ill_s;
    logic [TAG_W-1:0]  head_tag_r, head_tag_s;
    logic              push_s, pop_s;

    // Pointer advance with explicit wrap so DEPTH=1 also works
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    alu_ctrl_decode #(
        .CTRL_W   (CTRL_W),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .alu_op    (i_alu_op),
        .funct_3   (i_funct_3),
        .funct_7   (i_funct_7),
        .op_is_reg (i_op_is_reg),
        .alu_ctrl  (dec_ctrl_s),
        .illegal   (dec_ill_s)
    );

    // ready/valid are flops, so push never depends on i_ready
    assign push_s = i_valid & ready_r;
    assign pop_s  = valid_r & i_ready;

    // Next-state for pointers, count and the head-of-queue output registers
    always_comb begin
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        head_ctrl_s = head_ctrl_r;
        head_ill_s  = head_ill_r;
        head_tag_s  = head_tag_r;
        if (i_flush) begin
            wr_ptr_s = {PTR_W{1'b0}};
            rd_ptr_s = {PTR_W{1'b0}};
            count_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
            // Head reloads from the new read slot; if that slot is being
            // written this cycle the incoming entry is forwarded. When the
            // FIFO drains the head keeps its last value.
            if (count_s != {CNT_W{1'b0}}) begin
                if (push_s && (wr_ptr_r == rd_ptr_s)) begin
                    head_ctrl_s = dec_ctrl_s;
                    head_ill_s  = dec_ill_s;
                    head_tag_s  = i_tag;
                end else begin
                    head_ctrl_s = ctrl_mem_r[rd_ptr_s];
                    head_ill_s  = ill_mem_r[rd_ptr_s];
                    head_tag_s  = tag_mem_r[rd_ptr_s];
                end
            end else begin
                head_ctrl_s = head_ctrl_r;
            end
        end
    end

    // Control state and head output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
            ready_r     <= 1'b1;
            head_ctrl_r <= {CTRL_W{1'b0}};
            head_ill_r  <= 1'b0;
            head_tag_r  <= {TAG_W{1'b0}};
        end else begin
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            valid_r     <= (count_s != {CNT_W{1'b0}});
            ready_r     <= (count_s != CNT_W'(DEPTH));
            head_ctrl_r <= head_ctrl_s;
            head_ill_r  <= head_ill_s;
            head_tag_r  <= head_tag_s;
        end
    end

    // FIFO storage, written at push with the decoded entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_mem_r[i] <= {CTRL_W{1'b0}};
                ill_mem_r[i]  <= 1'b0;
                tag_mem_r[i]  <= {TAG_W{1'b0}};
            end
        end else if (push_s && !i_flush) begin
            ctrl_mem_r[wr_ptr_r] <= dec_ctrl_s;
            ill_mem_r[wr_ptr_r]  <= dec_ill_s;
            tag_mem_r[wr_ptr_r]  <= i_tag;
        end
    end

    assign o_ready    = ready_r;
    assign o_valid    = valid_r;
    assign o_count    = count_r;
    assign o_alu_ctrl = head_ctrl_r;
    assign o_illegal  = head_ill_r;
    assign o_tag      = head_tag_r;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: a scoreboard queue is filled when
// a request is accepted and a monitor pops and compares whenever the stage
// hands an entry downstream. Two instances (ENABLE_M=1 and 0) share stimulus.
module tb_alu_decode_stage;

    localparam int TAG_W = 32;

    typedef struct {
        logic [31:0] tag;
        logic [4:0]  ctrl_m;
        logic        ill_m;
        logic [4:0]  ctrl_nm;
        logic        ill_nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  f3 = 3'b000;
    logic [6:0]  f7 = 7'b0000000;
    logic        is_reg = 1'b0;
    logic [31:0] tag = 32'h0;

    logic        o_ready, o_valid, o_illegal;
    logic [4:0]  o_ctrl;
    logic [31:0] o_tag;
    logic [1:0]  o_count;
    logic        n_ready, n_valid, n_illegal;
    logic [4:0]  n_ctrl;
    logic [31:0] n_tag;
    logic [1:0]  n_count;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.CTRL_W(5), .TAG_W(TAG_W), .DEPTH(2), .ENABLE_M(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
        .i_alu_op(alu_op), .i_funct_3(f3), .i_funct_7(f7), .i_op_is_reg(is_reg),
        .i_tag(tag), .o_valid(o_valid), .i_ready(ready), .o_alu_ctrl(o_ctrl),
        .o_illegal(o_illegal), .o_tag(o_tag), .o_count(o_count)
    );

    alu_decode_stage #(.CTRL_W(5), .TAG_W(TAG_W), .DEPTH(2), .ENABLE_M(1'b0)) dut_nm (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(n_ready),
        .i_alu_op(alu_op), .i_funct_3(f3), .i_funct_7(f7), .i_op_is_reg(is_reg),
        .i_tag(tag), .o_valid(n_valid), .i_ready(ready), .o_alu_ctrl(n_ctrl),
        .o_illegal(n_illegal), .o_tag(n_tag), .o_count(n_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules; returns {illegal, code}
    function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [2:0] fn3,
                                              input logic [6:0] fn7, input logic rr,
                                              input logic m_en);
        int base_tab[8];
        int br_tab[8];
        int code;
        bit bad;
        base_tab = '{3, 5, 7, 8, 2, 6, 1, 0};      // ADD SLL SLT SLTU XOR SRL OR AND
        br_tab   = '{10, 11, -1, -1, 12, 14, 13, 15};
        bad  = 0;
        code = 3;
        if (op == 2'b00) code = 3;
        else if (op == 2'b10) code = 4;
        else if (op == 2'b11) begin
            if (br_tab[fn3] < 0) bad = 1; else code = br_tab[fn3];
        end else if (rr) begin
            if (fn7 == 7'h01) begin
                if (m_en) code = 16 + int'(fn3); else bad = 1;
            end else if (fn7 == 7'h20) begin
                if (fn3 == 3'd0) code = 4;
                else if (fn3 == 3'd5) code = 9;
                else bad = 1;
            end else if (fn7 == 7'h00) code = base_tab[fn3];
            else bad = 1;
        end else begin
            code = base_tab[fn3];
            if (fn3 == 3'd1 && fn7 != 7'h00) bad = 1;
            if (fn3 == 3'd5) begin
                if (fn7 == 7'h20) code = 9;
                else if (fn7 != 7'h00) bad = 1;
            end
        end
        if (bad) code = 3;
        return {bad, 5'(code)};
    endfunction

    // Advance one cycle; record accepted requests in the scoreboard
    task automatic step();
        logic [5:0] em;
        logic [5:0] enm;
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else if (valid && o_ready) begin
                em  = ref_decode(alu_op, f3, f7, is_reg, 1'b1);
                enm = ref_decode(alu_op, f3, f7, is_reg, 1'b0);
                e.tag = tag; e.ctrl_m = em[4:0]; e.ill_m = em[5];
                e.ctrl_nm = enm[4:0]; e.ill_nm = enm[5];
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        logic [6:0] pick[4];
        pick = '{7'h00, 7'h20, 7'h01, 7'h7F};
        alu_op = 2'($urandom_range(0, 3));
        f3     = 3'($urandom_range(0, 7));
        f7     = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pick[$urandom_range(0, 3)];
        is_reg = 1'($urandom);
        tag    = $urandom;
    endtask

    // Monitor: compare every handed-off entry against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid && ready && !flush) begin
            if (q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_output: got tag %0h expected no entry", o_tag);
            end else begin
                e = q.pop_front();
                chk("tag", 64'(o_tag), 64'(e.tag));
                chk("ctrl_m", 64'(o_ctrl), 64'(e.ctrl_m));
                chk("ill_m", 64'(o_illegal), 64'(e.ill_m));
                chk("ctrl_nm", 64'(n_ctrl), 64'(e.ctrl_nm));
                chk("ill_nm", 64'(n_illegal), 64'(e.ill_nm));
            end
        end
    end

    initial begin
        logic [6:0] f7set[4];
        f7set = '{7'h00, 7'h20, 7'h01, 7'h7F};

        // Reset state
        #12;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_ctrl", 64'(o_ctrl), 64'd0);
        chk("rst_ill", 64'(o_illegal), 64'd0);
        chk("rst_tag", 64'(o_tag), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single AND push, one-cycle latency
        ready = 1'b1; valid = 1'b1; alu_op = 2'b01; f3 = 3'b111; f7 = 7'h00;
        is_reg = 1'b1; tag = 32'h100;
        step();
        valid = 1'b0;
        chk("first_valid", 64'(o_valid), 64'd1);
        chk("first_ctrl", 64'(o_ctrl), 64'd0);
        chk("first_tag", 64'(o_tag), 64'h100);
        step();
        chk("first_drained", 64'(o_valid), 64'd0);

        // Decode sweep
        valid = 1'b1;
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 8; a++)
                for (int k = 0; k < 4; k++)
                    for (int r = 0; r < 2; r++) begin
                        alu_op = 2'(op); f3 = 3'(a); f7 = f7set[k]; is_reg = 1'(r);
                        tag = 32'((op << 8) | (a << 4) | (k << 1) | r);
                        step();
                    end
        valid = 1'b0;
        repeat (3) step();

        // Backpressure: A,B fill, C waits until after first pop
        ready = 1'b0; valid = 1'b1;
        rand_fields(); tag = 32'hA; step();
        rand_fields(); tag = 32'hB; step();
        chk("full_count", 64'(o_count), 64'd2);
        chk("full_ready", 64'(o_ready), 64'd0);
        rand_fields(); tag = 32'hC; step();
        chk("hold_count", 64'(o_count), 64'd2);
        chk("hold_ready", 64'(o_ready), 64'd0);
        chk("hold_tag", 64'(o_tag), 64'hA);
        ready = 1'b1; step();
        chk("pop1_count", 64'(o_count), 64'd1);
        chk("pop1_ready", 64'(o_ready), 64'd1);
        chk("pop1_tag", 64'(o_tag), 64'hB);
        step();
        chk("c_in_count", 64'(o_count), 64'd1);
        chk("c_in_tag", 64'(o_tag), 64'hC);
        valid = 1'b0; step();
        chk("bp_empty", 64'(o_count), 64'd0);

        // Streaming: one result per cycle, occupancy steady at 1
        valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_fields(); step();
            chk("stream_count", 64'(o_count), 64'd1);
        end
        valid = 1'b0; step();

        // Flush of a full FIFO with a concurrent push
        ready = 1'b0; valid = 1'b1;
        rand_fields(); step();
        rand_fields(); step();
        chk("pre_flush_count", 64'(o_count), 64'd2);
        rand_fields(); tag = 32'hDEAD; flush = 1'b1; step();
        flush = 1'b0; valid = 1'b0;
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        ready = 1'b1; repeat (2) step();

        // Asynchronous reset mid-burst
        ready = 1'b0; valid = 1'b1;
        rand_fields(); step();
        rand_fields(); step();
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_count", 64'(o_count), 64'd0);
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_ctrl", 64'(o_ctrl), 64'd0);
        chk("arst_tag", 64'(o_tag), 64'd0);
        valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        ready = 1'b1; valid = 1'b1;
        alu_op = 2'b01; f3 = 3'b100; f7 = 7'h01; is_reg = 1'b1; tag = 32'h55;
        step();
        valid = 1'b0;
        chk("post_rst_tag", 64'(o_tag), 64'h55);
        chk("post_rst_ctrl", 64'(o_ctrl), 64'd20);
        chk("post_rst_nm_ill", 64'(n_illegal), 64'd1);
        step();

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            rand_fields();
            valid = 1'($urandom);
            ready = 1'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0; valid = 1'b0; ready = 1'b1;

        // Drain, bounded
        for (int i = 0; i < 8 && q.size() != 0; i++) step();
        chk("drain_left", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
